// File: rtl/seg_display_scheduler.sv
// Shares the 4-digit seven-segment display between up to four requesters using
// round-robin arbitration at frame boundaries, and scans the digits with per-slot blanking.
module seg_display_scheduler #(
  parameter int N_SRC       = 4,
  parameter int SCAN_DIV    = 100000,
  parameter int BLANK_CYC   = 1000,
  parameter int HOLD_FRAMES = 250
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    req,
  input  logic [16*N_SRC-1:0] src_data,
  output logic [N_SRC-1:0]    grant,
  output logic [15:0]         disp_value,
  output logic [3:0]          nibble,
  output logic [3:0]          anode,
  output logic                frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HC_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int IDX_W = $clog2(N_SRC);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [HC_W-1:0]  HOLD_MAX  = HC_W'(HOLD_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N_SRC - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       digit_reg, digit_next;
  logic [HC_W-1:0]  hold_reg, hold_next;
  logic [IDX_W-1:0] rr_reg, rr_next;
  logic [IDX_W-1:0] owner_reg, owner_next;
  logic [N_SRC-1:0] grant_reg, grant_next;
  logic [15:0]      disp_reg, disp_next;
  logic [3:0]       nibble_reg, nibble_next;
  logic [3:0]       anode_reg, anode_next;
  logic             tick_reg;

  logic             slot_end, frame_end;
  logic             pick_found, others_pending, take;
  logic [IDX_W-1:0] pick_idx, cand;
  logic [15:0]      src_arr [N_SRC];

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign src_arr[gi] = src_data[16*gi +: 16];
    end
  endgenerate

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_MAX) ? '0 : i + 1'b1;
  endfunction

  assign slot_end  = (cnt_reg == CNT_MAX);
  assign frame_end = slot_end && (digit_reg == 2'd3);
  assign cnt_next   = slot_end ? '0 : cnt_reg + 1'b1;
  assign digit_next = slot_end ? digit_reg + 2'd1 : digit_reg;

  // rr_reg always sits one past the owner, so a single search from it serves
  // both the idle pick and the "next after owner" pick.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = rr_reg;
    for (int k = 0; k < N_SRC; k++) begin
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  assign others_pending = |(req & ~grant_reg);

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    hold_next  = hold_reg;
    rr_next    = rr_reg;
    grant_next = grant_reg;
    disp_next  = disp_reg;
    take       = 1'b0;
    if (frame_end) begin
      case (state_reg)
        IDLE: take = pick_found;
        OWN: begin
          if (!req[owner_reg]) begin
            if (pick_found) begin
              take = 1'b1;
            end else begin
              state_next = IDLE;
              grant_next = '0;
            end
          end else if (others_pending && hold_reg == HOLD_MAX) begin
            take = 1'b1;
          end else begin
            if (hold_reg != HOLD_MAX) hold_next = hold_reg + 1'b1;
            disp_next = src_arr[owner_reg];
          end
        end
        default: state_next = IDLE;
      endcase
      if (take) begin
        state_next = OWN;
        owner_next = pick_idx;
        hold_next  = '0;
        rr_next    = wrap_inc(pick_idx);
        grant_next = N_SRC'(1) << pick_idx;
        disp_next  = src_arr[pick_idx];
      end
    end
  end

  // Scan outputs are computed from next-state values so they line up with the slot counter.
  always_comb begin
    if (state_next == IDLE || cnt_next < BLANK_END) anode_next = 4'b1111;
    else                                            anode_next = ~(4'b0001 << digit_next);
    nibble_next = disp_next[{digit_next, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      digit_reg  <= '0;
      hold_reg   <= '0;
      rr_reg     <= '0;
      owner_reg  <= '0;
      grant_reg  <= '0;
      disp_reg   <= '0;
      nibble_reg <= '0;
      anode_reg  <= 4'b1111;
      tick_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      digit_reg  <= digit_next;
      hold_reg   <= hold_next;
      rr_reg     <= rr_next;
      owner_reg  <= owner_next;
      grant_reg  <= grant_next;
      disp_reg   <= disp_next;
      nibble_reg <= nibble_next;
      anode_reg  <= anode_next;
      tick_reg   <= frame_end;
    end
  end

  assign grant      = grant_reg;
  assign disp_value = disp_reg;
  assign nibble     = nibble_reg;
  assign anode      = anode_reg;
  assign frame_tick = tick_reg;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench for seg_display_scheduler with a 40-cycle frame
// (10 cycles per slot, 2 blank cycles, grants held for 3 frames).
module tb_seg_display_scheduler;
  localparam int N_SRC = 4, SCAN_DIV = 10, BLANK_CYC = 2, HOLD_FRAMES = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [63:0] src_data = {16'hBBBB, 16'h5678, 16'hAAAA, 16'h1234};
  logic [3:0]  grant;
  logic [15:0] disp_value;
  logic [3:0]  nibble;
  logic [3:0]  anode;
  logic        frame_tick;

  typedef struct packed { logic [3:0] anode; logic [3:0] nibble; } scan_t;
  typedef struct packed { logic [3:0] grant; logic [15:0] disp; } own_t;

  scan_t scan_q[$];
  own_t  own_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  seg_display_scheduler #(
    .N_SRC(N_SRC), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .src_data(src_data), .grant(grant),
    .disp_value(disp_value), .nibble(nibble), .anode(anode), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Expected scan for one frame: 2 blank cycles then 8 lit cycles per digit.
  task automatic push_frame(input logic [15:0] value);
    scan_t s;
    logic [15:0] v;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        v = value >> (4 * d);
        s.nibble = v[3:0];
        s.anode  = (c < BLANK_CYC) ? 4'b1111 : an_tab[d];
        scan_q.push_back(s);
      end
    end
  endtask

  task automatic wait_tick(input int limit);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_tick !== 1'b1 && k < limit);
    if (frame_tick !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL tick_timeout: got no frame_tick in %0d cycles, required one", limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (anode !== 4'b1111) begin n_bad++; $display("FAIL reset_anode: got %b required 1111", anode); end
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b required 0000", grant); end
    n_cmp++; if (disp_value !== 16'h0000) begin n_bad++; $display("FAIL reset_disp: got %h required 0000", disp_value); end
    n_cmp++; if (nibble !== 4'h0) begin n_bad++; $display("FAIL reset_nibble: got %h required 0", nibble); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b required 0", frame_tick); end
    $display("reset: anode=%b grant=%b disp=%h", anode, grant, disp_value);
  endtask

  task automatic test_idle();
    int last, nt, bad;
    last = 0; nt = 0; bad = 0;
    rst = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (anode !== 4'b1111 || grant !== 4'b0000) bad++;
      if (frame_tick === 1'b1) begin
        if (last > 0) begin
          n_cmp++;
          if (k - last !== 4 * SCAN_DIV) begin
            n_bad++; $display("FAIL idle_tick_period: got %0d cycles required %0d", k - last, 4 * SCAN_DIV);
          end
        end
        last = k; nt++;
      end
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL idle_outputs: got %0d bad cycles required 0", bad); end
    n_cmp++; if (nt < 4) begin n_bad++; $display("FAIL idle_tick_count: got %0d ticks required >=4", nt); end
    $display("idle: %0d frame ticks, %0d bad cycles", nt, bad);
  endtask

  task automatic test_single();
    own_t  e;
    scan_t s;
    req = 4'b0001;
    own_q.push_back(own_t'{grant: 4'b0001, disp: 16'h1234});
    wait_tick(100);
    e = own_q.pop_front();
    n_cmp++; if (grant !== e.grant) begin n_bad++; $display("FAIL single_grant: got %b required %b", grant, e.grant); end
    n_cmp++; if (disp_value !== e.disp) begin n_bad++; $display("FAIL single_disp: got %h required %h", disp_value, e.disp); end
    $display("single: grant=%b disp=%h", grant, disp_value);
    push_frame(16'h1234);
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      if (i > 0) @(negedge clk);
      s = scan_q.pop_front();
      n_cmp++;
      if (anode !== s.anode || nibble !== s.nibble) begin
        n_bad++;
        $display("FAIL single_scan[%0d]: got anode=%b nibble=%h required anode=%b nibble=%h",
                 i, anode, nibble, s.anode, s.nibble);
      end
    end
  endtask

  task automatic test_round_robin();
    own_t e;
    logic [3:0] cur_g;
    int k, glitch;
    req = 4'b0000;
    wait_tick(100);
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL release_idle: got %b required 0000", grant); end
    req = 4'b0101;
    for (int f = 0; f < 9; f++)
      own_q.push_back((f / 3) % 2 == 0 ? own_t'{grant: 4'b0100, disp: 16'h5678}
                                       : own_t'{grant: 4'b0001, disp: 16'h1234});
    cur_g = 4'b0000; glitch = 0;
    for (int f = 0; f < 9; f++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
        if (frame_tick !== 1'b1 && grant !== cur_g) glitch++;
      end while (frame_tick !== 1'b1 && k < 60);
      if (frame_tick !== 1'b1) begin n_cmp++; n_bad++; $display("FAIL rr_tick_timeout: got none required tick"); end
      e = own_q.pop_front();
      n_cmp++; if (grant !== e.grant) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b required %b", f, grant, e.grant); end
      n_cmp++; if (disp_value !== e.disp) begin n_bad++; $display("FAIL rr_disp[%0d]: got %h required %h", f, disp_value, e.disp); end
      $display("rr frame %0d: grant=%b disp=%h", f, grant, disp_value);
      cur_g = e.grant;
    end
    n_cmp++; if (glitch !== 0) begin n_bad++; $display("FAIL rr_midframe_change: got %0d required 0", glitch); end
  endtask

  task automatic test_release();
    own_t e;
    int bad, k;
    own_q.push_back(own_t'{grant: 4'b0001, disp: 16'h1234});
    own_q.push_back(own_t'{grant: 4'b0100, disp: 16'h5678});
    wait_tick(100);
    e = own_q.pop_front();
    n_cmp++; if (grant !== e.grant) begin n_bad++; $display("FAIL release_pre_grant: got %b required %b", grant, e.grant); end
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (grant !== 4'b0001 || disp_value !== 16'h1234) bad++;
    end
    req = 4'b0100;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (frame_tick !== 1'b1 && (grant !== 4'b0001 || disp_value !== 16'h1234)) bad++;
    end while (frame_tick !== 1'b1 && k < 60);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL release_midframe: got %0d early changes required 0", bad); end
    e = own_q.pop_front();
    n_cmp++; if (grant !== e.grant) begin n_bad++; $display("FAIL release_grant: got %b required %b", grant, e.grant); end
    n_cmp++; if (disp_value !== e.disp) begin n_bad++; $display("FAIL release_disp: got %h required %h", disp_value, e.disp); end
    $display("release: grant=%b disp=%h", grant, disp_value);
  endtask

  task automatic test_data_change();
    own_t  e;
    scan_t s;
    push_frame(16'h5678);
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      if (i > 0) @(negedge clk);
      s = scan_q.pop_front();
      n_cmp++;
      if (anode !== s.anode || nibble !== s.nibble) begin
        n_bad++;
        $display("FAIL change_old_scan[%0d]: got anode=%b nibble=%h required anode=%b nibble=%h",
                 i, anode, nibble, s.anode, s.nibble);
      end
      if (i == 15) src_data[47:32] = 16'h9ABC;
    end
    own_q.push_back(own_t'{grant: 4'b0100, disp: 16'h9ABC});
    push_frame(16'h9ABC);
    wait_tick(100);
    e = own_q.pop_front();
    n_cmp++; if (disp_value !== e.disp) begin n_bad++; $display("FAIL change_disp: got %h required %h", disp_value, e.disp); end
    $display("data change: disp=%h", disp_value);
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      if (i > 0) @(negedge clk);
      s = scan_q.pop_front();
      n_cmp++;
      if (anode !== s.anode || nibble !== s.nibble) begin
        n_bad++;
        $display("FAIL change_new_scan[%0d]: got anode=%b nibble=%h required anode=%b nibble=%h",
                 i, anode, nibble, s.anode, s.nibble);
      end
    end
  endtask

  task automatic test_async_reset();
    own_t e;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (anode !== 4'b1111) begin n_bad++; $display("FAIL async_anode: got %b required 1111", anode); end
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL async_grant: got %b required 0000", grant); end
    n_cmp++; if (disp_value !== 16'h0000) begin n_bad++; $display("FAIL async_disp: got %h required 0000", disp_value); end
    $display("async reset: anode=%b grant=%b", anode, grant);
    req = 4'b1001;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    own_q.push_back(own_t'{grant: 4'b0001, disp: 16'h1234});
    wait_tick(100);
    e = own_q.pop_front();
    n_cmp++; if (grant !== e.grant) begin n_bad++; $display("FAIL post_reset_grant: got %b required %b", grant, e.grant); end
    n_cmp++; if (disp_value !== e.disp) begin n_bad++; $display("FAIL post_reset_disp: got %h required %h", disp_value, e.disp); end
    $display("post reset: grant=%b disp=%h", grant, disp_value);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_round_robin();
    test_release();
    test_data_change();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
